// File: rtl/mtm_alu_frame_deser.sv
// Byte-framed serial deserializer for the MTM ALU: collects 2*DATA_W/8 data bytes plus a CTL byte,
// checks framing and CRC4, strobes operands or an error byte. Optional macro: FRAME_TIMEOUT_EN.
module mtm_alu_frame_deser #(
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sin,
    output logic [DATA_W-1:0] a,
    output logic [DATA_W-1:0] b,
    output logic [2:0]        op,
    output logic              out_valid,
    output logic              err_valid,
    output logic [7:0]        err_code,
    output logic              busy
);
    localparam int NB = 2*DATA_W/8;
    localparam int BW = $clog2(NB+1);
    localparam int FW = 2*DATA_W;
    localparam logic [BW-1:0] NB_C = BW'(NB);

    if ((DATA_W % 8) != 0 || DATA_W < 8 || DATA_W > 64 || TIMEOUT_CYC < 1) begin : g_bad_param
        $error("mtm_alu_frame_deser: illegal DATA_W or TIMEOUT_CYC");
    end

    typedef enum logic [2:0] {IDLE, TYPE, DATA, STOP, CHECK, ERR} state_t;

    state_t          state, state_d;
    logic [BW-1:0]   byte_cnt;
    logic [2:0]      bit_cnt;
    logic            is_ctl;
    logic [7:0]      byte_sr;
    logic [FW-1:0]   frame_buf;
    logic [3:0]      crc;
    logic            crc_in, crc_fb, crc_ok;
    logic [3:0]      crc_next;
    logic            to_hit;

    // The CTL MSB is not covered; a constant 1 takes its slot in the CRC stream.
    assign crc_in   = (is_ctl && bit_cnt == 3'd0) ? 1'b1 : sin;
    assign crc_fb   = crc_in ^ crc[3];
    assign crc_next = {crc[2:0], 1'b0} ^ (crc_fb ? 4'b0011 : 4'b0000);
    assign crc_ok   = (crc == byte_sr[3:0]);
    assign busy     = (state != IDLE) || (byte_cnt != '0);

`ifdef FRAME_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC+1);
    logic [TW-1:0] to_cnt;

    assign to_hit = (state == IDLE) && (byte_cnt != '0) && sin && (to_cnt == TW'(TIMEOUT_CYC-1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            to_cnt <= '0;
        else if (state == IDLE && byte_cnt != '0 && sin && !to_hit)
            to_cnt <= to_cnt + TW'(1);
        else
            to_cnt <= '0;
    end
`else
    assign to_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:  if (to_hit) state_d = ERR;
                   else if (!sin) state_d = TYPE;
            TYPE:  if ((!sin && byte_cnt < NB_C) || (sin && byte_cnt == NB_C)) state_d = DATA;
                   else state_d = ERR;
            DATA:  if (bit_cnt == 3'd7) state_d = STOP;
            STOP:  if (!sin) state_d = ERR;
                   else if (is_ctl) state_d = CHECK;
                   else state_d = IDLE;
            CHECK: state_d = IDLE;
            ERR:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a         <= '1;
            b         <= '1;
            op        <= 3'b111;
            out_valid <= 1'b0;
            err_valid <= 1'b0;
            err_code  <= 8'h00;
            byte_cnt  <= '0;
            bit_cnt   <= '0;
            is_ctl    <= 1'b0;
            byte_sr   <= '0;
            frame_buf <= '0;
            crc       <= '0;
        end else begin
            out_valid <= 1'b0;
            err_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (!sin && byte_cnt == '0) crc <= '0;
                end
                TYPE: begin
                    is_ctl  <= sin;
                    bit_cnt <= '0;
                end
                DATA: begin
                    byte_sr <= {byte_sr[6:0], sin};
                    bit_cnt <= bit_cnt + 3'd1;
                    if (!is_ctl || !bit_cnt[2]) crc <= crc_next;
                end
                STOP: begin
                    if (sin && !is_ctl) begin
                        frame_buf <= {frame_buf[FW-9:0], byte_sr};
                        byte_cnt  <= byte_cnt + BW'(1);
                    end
                end
                CHECK: begin
                    if (crc_ok) begin
                        b         <= frame_buf[FW-1:DATA_W];
                        a         <= frame_buf[DATA_W-1:0];
                        op        <= byte_sr[6:4];
                        out_valid <= 1'b1;
                    end else begin
                        err_valid <= 1'b1;
                        err_code  <= 8'hA5;
                    end
                    byte_cnt  <= '0;
                    crc       <= '0;
                    frame_buf <= '0;
                end
                ERR: begin
                    err_valid <= 1'b1;
                    err_code  <= 8'hC9;
                    byte_cnt  <= '0;
                    bit_cnt   <= '0;
                    byte_sr   <= '0;
                    frame_buf <= '0;
                    crc       <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mtm_alu_frame_deser.sv
// Directed bench for mtm_alu_frame_deser: 32-bit and 16-bit instances on separate serial lines.
module tb_mtm_alu_frame_deser;
    logic        clk = 1'b0, rst_n = 1'b0, sin32 = 1'b1, sin16 = 1'b1;
    logic [31:0] a32, b32;
    logic [15:0] a16, b16;
    logic [2:0]  op32, op16;
    logic        ov_32, ev_32, busy32, ov_16, ev_16, busy16;
    logic [7:0]  ec_32, ec_16;

    int          checks = 0, errors = 0;
    int          ov32 = 0, ev32 = 0, ov16 = 0, ev16 = 0;
    int          ov_s, ev_s;
    logic [7:0]  code32 = 8'h00, code16 = 8'h00;
    logic        sel16 = 1'b0;
    logic [7:0]  dbytes [8];

    mtm_alu_frame_deser #(.DATA_W(32), .TIMEOUT_CYC(64)) dut32 (
        .clk(clk), .rst_n(rst_n), .sin(sin32), .a(a32), .b(b32), .op(op32),
        .out_valid(ov_32), .err_valid(ev_32), .err_code(ec_32), .busy(busy32));

    mtm_alu_frame_deser #(.DATA_W(16), .TIMEOUT_CYC(64)) dut16 (
        .clk(clk), .rst_n(rst_n), .sin(sin16), .a(a16), .b(b16), .op(op16),
        .out_valid(ov_16), .err_valid(ev_16), .err_code(ec_16), .busy(busy16));

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ov_32 || ev_32) begin
            checks++;
            assert (!(ov_32 && ev_32)) else begin errors++; $error("FAIL strobe_excl32 observed=both expected=one"); end
        end
        if (ov_16 || ev_16) begin
            checks++;
            assert (!(ov_16 && ev_16)) else begin errors++; $error("FAIL strobe_excl16 observed=both expected=one"); end
        end
        if (ov_32) ov32++;
        if (ev_32) begin ev32++; code32 = ec_32; end
        if (ov_16) ov16++;
        if (ev_16) begin ev16++; code16 = ec_16; end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic v);
        if (sel16) sin16 = v; else sin32 = v;
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic t, input logic [7:0] v, input logic stp);
        send_bit(1'b0);
        send_bit(t);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
        send_bit(stp);
    endtask

    task automatic send_data(input int from, input int upto);
        for (int i = from; i < upto; i++) send_byte(1'b0, dbytes[i], 1'b1);
    endtask

    // Reference CRC4 (x^4+x+1, MSB first) over data bytes, a constant 1, then the op bits.
    function automatic logic [3:0] crc_calc(input int nd, input logic [2:0] opv);
        logic [3:0] c;
        logic       fb;
        logic [7:0] bt;
        logic [10:0] tail;
        c = 4'h0;
        for (int i = 0; i < nd; i++) begin
            bt = dbytes[i];
            for (int j = 7; j >= 0; j--) begin
                fb = bt[j] ^ c[3];
                c  = {c[2:0], 1'b0} ^ (fb ? 4'b0011 : 4'b0000);
            end
        end
        tail = {8'h00, 3'b000} | {7'h00, 1'b1, opv};
        for (int j = 3; j >= 0; j--) begin
            fb = tail[j] ^ c[3];
            c  = {c[2:0], 1'b0} ^ (fb ? 4'b0011 : 4'b0000);
        end
        return c;
    endfunction

    task automatic send_ctl(input int nd, input logic [2:0] opv);
        send_byte(1'b1, {1'b0, opv, crc_calc(nd, opv)}, 1'b1);
    endtask

    task automatic set_zero();
        for (int i = 0; i < 8; i++) dbytes[i] = 8'h00;
    endtask

    task automatic set_pattern();
        dbytes[0] = 8'h11; dbytes[1] = 8'h22; dbytes[2] = 8'h33; dbytes[3] = 8'h44;
        dbytes[4] = 8'hA5; dbytes[5] = 8'hC3; dbytes[6] = 8'h0F; dbytes[7] = 8'h81;
    endtask

    initial begin
        set_zero();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_a", a32, 32'hFFFF_FFFF);
        chk("rst_b", b32, 32'hFFFF_FFFF);
        chk("rst_op", op32, 3'b111);
        chk("rst_ov", ov_32, 1'b0);
        chk("rst_ev", ev_32, 1'b0);
        chk("rst_code", ec_32, 8'h00);
        chk("rst_busy", busy32, 1'b0);
        rst_n = 1'b1;
        send_bit(1'b1); send_bit(1'b1);

        // all-zero frame, CTL 0B, two-cycle latency, minimum gap
        send_data(0, 8);
        send_byte(1'b1, 8'h0B, 1'b1);
        chk("lat_ov_early", ov_32, 1'b0);
        chk("busy_in_check", busy32, 1'b1);
        send_bit(1'b1);
        chk("z_ov", ov_32, 1'b1);
        chk("z_a", a32, 32'h0);
        chk("z_b", b32, 32'h0);
        chk("z_op", op32, 3'd0);
        chk("z_busy", busy32, 1'b0);

        send_data(0, 8);
        send_byte(1'b1, 8'h18, 1'b1);
        send_bit(1'b1);
        chk("op1_ov", ov_32, 1'b1);
        chk("op1_op", op32, 3'b001);

        send_data(0, 8);
        send_byte(1'b1, 8'h0C, 1'b1);
        chk("crc_ev_early", ev_32, 1'b0);
        send_bit(1'b1);
        chk("crc_ev", ev_32, 1'b1);
        chk("crc_code", ec_32, 8'hA5);
        chk("crc_ov", ov_32, 1'b0);
        chk("crc_op_hold", op32, 3'b001);
        send_bit(1'b1);

        // byte ordering: first half -> b, second half -> a
        set_pattern();
        send_data(0, 1);
        chk("busy_between", busy32, 1'b1);
        send_data(1, 8);
        send_ctl(8, 3'd5);
        send_bit(1'b1);
        chk("pat_ov", ov_32, 1'b1);
        chk("pat_b", b32, 32'h1122_3344);
        chk("pat_a", a32, 32'hA5C3_0F81);
        chk("pat_op", op32, 3'd5);

        // CTL after only 7 data bytes
        send_data(0, 7);
        send_bit(1'b0); send_bit(1'b1);
        send_bit(1'b1);
        chk("short_ev", ev_32, 1'b1);
        chk("short_code", ec_32, 8'hC9);
        chk("short_a_hold", a32, 32'hA5C3_0F81);
        repeat (3) send_bit(1'b1);
        set_zero();
        send_data(0, 8);
        send_ctl(8, 3'd3);
        send_bit(1'b1);
        chk("after_short_ov", ov_32, 1'b1);
        chk("after_short_op", op32, 3'd3);
        chk("after_short_a", a32, 32'h0);

        // bad stop bit on byte 3
        send_data(0, 2);
        send_byte(1'b0, 8'h00, 1'b0);
        send_bit(1'b1);
        chk("stop_ev", ev_32, 1'b1);
        chk("stop_code", ec_32, 8'hC9);
        repeat (10) send_bit(1'b1);
        set_pattern();
        send_data(0, 8);
        send_ctl(8, 3'd6);
        send_bit(1'b1);
        chk("after_stop_ov", ov_32, 1'b1);
        chk("after_stop_op", op32, 3'd6);
        chk("after_stop_b", b32, 32'h1122_3344);

        // 16-bit instance
        sel16 = 1'b1;
        set_zero();
        send_data(0, 4);
        send_byte(1'b1, 8'h0B, 1'b1);
        send_bit(1'b1);
        chk("w16_ov", ov_16, 1'b1);
        chk("w16_a", a16, 16'h0);
        chk("w16_b", b16, 16'h0);
        ev_s = ev16;
        send_data(0, 4);
        send_byte(1'b0, 8'hFF, 1'b1);
        send_bit(1'b1); send_bit(1'b1);
        chk("w16_long_evcnt", ev16, ev_s + 1);
        chk("w16_long_code", code16, 8'hC9);
        set_pattern();
        send_data(0, 4);
        send_ctl(4, 3'd2);
        send_bit(1'b1);
        chk("w16_pat_ov", ov_16, 1'b1);
        chk("w16_pat_b", b16, 16'h1122);
        chk("w16_pat_a", a16, 16'h3344);
        chk("w16_pat_op", op16, 3'd2);
        sel16 = 1'b0;

        // reset during byte 5
        send_data(0, 4);
        send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
        ov_s = ov32; ev_s = ev32;
        rst_n = 1'b0;
        #1;
        chk("mrst_a", a32, 32'hFFFF_FFFF);
        chk("mrst_b", b32, 32'hFFFF_FFFF);
        chk("mrst_op", op32, 3'b111);
        chk("mrst_busy", busy32, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sin32 = 1'b1;
        send_bit(1'b1); send_bit(1'b1);
        chk("mrst_ovcnt", ov32, ov_s);
        chk("mrst_evcnt", ev32, ev_s);
        send_data(0, 8);
        send_ctl(8, 3'd4);
        send_bit(1'b1);
        chk("mrst_next_ov", ov_32, 1'b1);
        chk("mrst_next_a", a32, 32'hA5C3_0F81);
        chk("mrst_next_op", op32, 3'd4);

        // idle line inside a frame
        ev_s = ev32;
        send_data(0, 3);
        repeat (70) send_bit(1'b1);
`ifdef FRAME_TIMEOUT_EN
        chk("to_evcnt", ev32, ev_s + 1);
        chk("to_code", code32, 8'hC9);
        chk("to_busy", busy32, 1'b0);
        send_data(0, 8);
        send_ctl(8, 3'd1);
        send_bit(1'b1);
        chk("to_next_ov", ov_32, 1'b1);
        chk("to_next_op", op32, 3'd1);
`else
        chk("noto_evcnt", ev32, ev_s);
        chk("noto_busy", busy32, 1'b1);
        send_data(3, 8);
        send_ctl(8, 3'd1);
        send_bit(1'b1);
        chk("noto_ov", ov_32, 1'b1);
        chk("noto_b", b32, 32'h1122_3344);
        chk("noto_a", a32, 32'hA5C3_0F81);
        chk("noto_op", op32, 3'd1);
`endif
        send_bit(1'b1); send_bit(1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
